// File: rtl/bus_arbiter4.sv
// Round-robin arbiter sharing one 16-bit bus among four requesters.
// Holds a grant for one packet or MAX_BEATS transfers, then rotates priority.
module bus_arbiter4 #(
    parameter int MAX_BEATS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic [3:0] last,
    input  logic       out_ready,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       out_valid,
    output logic       busy
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;
    localparam logic [7:0] BEAT_LIMIT = 8'(MAX_BEATS - 1);

    logic [0:0] state_r;
    logic [1:0] ptr_r;
    logic [7:0] beats_r;
    logic [3:0] gnt_r;
    logic [1:0] sel_r;
    logic       busy_r;

    logic [2:0] pick_s;
    logic       xfer_s;
    logic       release_s;

    // Returns {found, index} of the first asserted request searching p, p+1, ... mod 4.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = p + i[1:0];
            if (r[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Arbitration pick and release decision for the current cycle.
    always_comb begin
        pick_s    = rr_pick(req, ptr_r);
        xfer_s    = out_valid & out_ready;
        release_s = 1'b0;
        if (state_r == GRANT) begin
            release_s = (xfer_s & last[sel_r])
                      | (xfer_s & (beats_r == BEAT_LIMIT))
                      | ~req[sel_r];
        end else begin
            release_s = 1'b0;
        end
    end

    // Grant state machine; sel deliberately keeps its value while idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            ptr_r   <= 2'd0;
            beats_r <= 8'd0;
            gnt_r   <= 4'b0000;
            sel_r   <= 2'd0;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pick_s[2]) begin
                        state_r <= GRANT;
                        gnt_r   <= 4'b0001 << pick_s[1:0];
                        sel_r   <= pick_s[1:0];
                        beats_r <= 8'd0;
                        busy_r  <= 1'b1;
                    end else begin
                        gnt_r   <= 4'b0000;
                        busy_r  <= 1'b0;
                    end
                end
                GRANT: begin
                    if (release_s) begin
                        state_r <= IDLE;
                        gnt_r   <= 4'b0000;
                        busy_r  <= 1'b0;
                        ptr_r   <= sel_r + 2'd1;
                    end else if (xfer_s) begin
                        beats_r <= beats_r + 8'd1;
                    end else begin
                        beats_r <= beats_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    gnt_r   <= 4'b0000;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt       = gnt_r;
    assign sel       = sel_r;
    assign busy      = busy_r;
    assign out_valid = busy_r & req[sel_r];

endmodule
